gbt_ps_capture_writer: RTL and testbench



---
 rtl/gbt_ps_capture_writer_pkg.sv | 17 +
 rtl/gbt_ps_capture_writer.sv | 166 ++++++++++++++++
 tb/tb_gbt_ps_capture_writer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gbt_ps_capture_writer_pkg.sv
// Shared types for the GBT-to-PS capture writer: clock/reset bundle and FSM state encoding.
package gbt_ps_capture_writer_pkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HEADER  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/gbt_ps_capture_writer.sv
// Captures a bounded burst of GBT user words into PS shared-memory BRAM and
// closes each record with a {seq, 8'h00, count} header word at BASE_ADDR.
module gbt_ps_capture_writer
  import gbt_ps_capture_writer_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  ckrs_t       ClkRs_ix,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        trigger_i,
  input  logic [31:0] control_i,
  output logic [31:0] status_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_addr_o,
  output logic [31:0] bram_din_o,
  output logic        done_o
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic clk;
  logic rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  logic ctrl_unused;
  assign ctrl_unused = ^control_i[31:5];

  state_e      state_q, state_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  seq_q, seq_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        done_pulse_q, done_pulse_d;
  logic [31:0] status_q, status_d;

  logic [4:0]  ctrl_edge;
  logic        arm_e, swtrig_e, stop_e, abort_e, clear_e;
  logic        trig_ev;
  logic [16:0] count_inc;

  always_comb begin
    ctrl_edge = control_i[4:0] & ~ctrl_q;
    arm_e     = ctrl_edge[0];
    swtrig_e  = ctrl_edge[1];
    stop_e    = ctrl_edge[2];
    abort_e   = ctrl_edge[3];
    clear_e   = ctrl_edge[4];
    trig_ev   = trigger_i | swtrig_e;
    count_inc = {1'b0, count_q} + 17'd1;

    state_d      = state_q;
    ctrl_d       = control_i[4:0];
    count_d      = count_q;
    seq_d        = seq_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    wr_d         = 1'b0;
    addr_d       = '0;
    din_d        = '0;
    done_pulse_d = 1'b0;
    // Status shows the registers as they stood before this edge, so it lags state by a cycle.
    status_d     = {count_q, seq_q, 3'b000, aborted_q, done_q, state_q};

    unique case (state_q)
      ST_IDLE: begin
        if (arm_e) begin
          state_d   = ST_ARMED;
          count_d   = '0;
          done_d    = 1'b0;
          aborted_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (abort_e) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (trig_ev) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Abort wins over a same-cycle valid word, stop edge or depth limit.
        if (abort_e) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          if (valid_i) begin
            wr_d    = 1'b1;
            addr_d  = BASE_ADDR + 32'd4 + {14'd0, count_q, 2'b00};
            din_d   = data_i;
            count_d = count_inc[15:0];
          end
          if ((valid_i && (count_inc == DEPTH_L)) || stop_e) begin
            state_d = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        wr_d         = 1'b1;
        addr_d       = BASE_ADDR;
        din_d        = {seq_q, 8'h00, count_q};
        seq_d        = seq_q + 8'd1;
        done_d       = 1'b1;
        done_pulse_d = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (arm_e) begin
          state_d   = ST_ARMED;
          count_d   = '0;
          done_d    = 1'b0;
          aborted_d = 1'b0;
        end else if (clear_e) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      done_pulse_q <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      done_pulse_q <= done_pulse_d;
      status_q     <= status_d;
    end
  end

  assign bram_en_o   = wr_q;
  assign bram_we_o   = {4{wr_q}};
  assign bram_addr_o = addr_q;
  assign bram_din_o  = din_q;
  assign done_o      = done_pulse_q;
  assign status_o    = status_q;

endmodule

// File: tb/tb_gbt_ps_capture_writer.sv
// Directed bench for gbt_ps_capture_writer: cycle model of the capture rules
// compared every cycle, plus hand-computed record and status values.
module tb_gbt_ps_capture_writer;
  import gbt_ps_capture_writer_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_HEADER = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ckrs_t       ckrs;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        trigger_i = 1'b0;
  logic [31:0] control_i = '0;
  logic [31:0] status_o;
  logic        bram_en_o;
  logic [3:0]  bram_we_o;
  logic [31:0] bram_addr_o;
  logic [31:0] bram_din_o;
  logic        done_o;

  assign ckrs.clk   = clk;
  assign ckrs.reset = rst;

  gbt_ps_capture_writer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .ClkRs_ix   (ckrs),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .trigger_i  (trigger_i),
    .control_i  (control_i),
    .status_o   (status_o),
    .bram_en_o  (bram_en_o),
    .bram_we_o  (bram_we_o),
    .bram_addr_o(bram_addr_o),
    .bram_din_o (bram_din_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the record rules; expected outputs reflect the last clock edge.
  int          m_state = S_IDLE;
  int          m_cnt = 0;
  int          m_seq = 0;
  bit          m_done = 1'b0;
  bit          m_abt = 1'b0;
  logic [4:0]  m_prev = '0;
  logic [4:0]  ev;
  bit          e_we = 1'b0;
  bit          e_donep = 1'b0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_din = '0;
  logic [31:0] e_status = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = S_IDLE; m_cnt = 0; m_seq = 0; m_done = 0; m_abt = 0; m_prev = '0;
      e_we = 0; e_donep = 0; e_addr = '0; e_din = '0; e_status = '0;
    end else begin
      e_status = {m_cnt[15:0], m_seq[7:0], 3'b000, m_abt, m_done, m_state[2:0]};
      e_we = 0; e_donep = 0; e_addr = '0; e_din = '0;
      ev = control_i[4:0] & ~m_prev;
      m_prev = control_i[4:0];
      case (m_state)
        S_IDLE:
          if (ev[0]) begin m_state = S_ARMED; m_cnt = 0; m_done = 0; m_abt = 0; end
        S_ARMED:
          if (ev[3]) begin m_state = S_IDLE; m_abt = 1; end
          else if (trigger_i || ev[1]) m_state = S_CAPTURE;
        S_CAPTURE:
          if (ev[3]) begin m_state = S_IDLE; m_abt = 1; end
          else begin
            if (valid_i) begin
              e_we = 1; e_addr = BASE + 32'd4 + 32'(4 * m_cnt); e_din = data_i;
              m_cnt = m_cnt + 1;
            end
            if (m_cnt == DEPTH || ev[2]) m_state = S_HEADER;
          end
        S_HEADER: begin
          e_we = 1; e_addr = BASE; e_din = {m_seq[7:0], 8'h00, m_cnt[15:0]};
          m_seq = (m_seq + 1) % 256; m_done = 1; e_donep = 1; m_state = S_DONE;
        end
        default:
          if (ev[0]) begin m_state = S_ARMED; m_cnt = 0; m_done = 0; m_abt = 0; end
          else if (ev[4]) m_state = S_IDLE;
      endcase
    end
  end

  // Record capture of BRAM writes and done pulses, used by the literal checks.
  bit [31:0]   mem [0:15];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_hdr = 32'hFFFF_FFFF;

  initial forever begin
    @(negedge clk);
    chk("bram_en", {31'd0, bram_en_o}, {31'd0, e_we});
    chk("bram_we", {28'd0, bram_we_o}, e_we ? 32'hF : 32'h0);
    chk("done_o", {31'd0, done_o}, {31'd0, e_donep});
    chk("status_o", status_o, e_status);
    if (e_we) begin
      chk("bram_addr", bram_addr_o, e_addr);
      chk("bram_din", bram_din_o, e_din);
    end
    if (bram_we_o == 4'hF) begin
      mem[bram_addr_o[5:2]] = bram_din_o;
      wr_cnt++;
      if (bram_addr_o == BASE) last_hdr = bram_din_o;
    end
    if (done_o) done_cnt++;
  end

  task automatic step(input logic [31:0] ctrl, input logic trig, input logic v, input logic [31:0] d);
    control_i = ctrl; trigger_i = trig; valid_i = v; data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  int w0, d0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", status_o, 32'h0);
    chk("reset_en", {31'd0, bram_en_o}, 32'h0);
    chk("reset_done", {31'd0, done_o}, 32'h0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Full capture: 10 words offered, only DEPTH=8 recorded.
    step(32'h1, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 1, 1, 32'hDEAD);
    for (int i = 0; i < 10; i++) step(32'h0, 0, 1, 32'h100 + 32'(i));
    idle(3);
    chk("t1_hdr", mem[0], 32'h0000_0008);
    chk("t1_first", mem[1], 32'h0000_0100);
    chk("t1_last", mem[8], 32'h0000_0107);
    chk("t1_beyond", mem[9], 32'h0);
    chk("t1_writes", 32'(wr_cnt), 32'd9);
    chk("t1_done_pulses", 32'(done_cnt), 32'd1);
    chk("t1_status", status_o, 32'h0008_010C);

    // Stop edge together with the 4th valid word.
    w0 = wr_cnt; d0 = done_cnt;
    step(32'h1, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    step(32'h2, 0, 0, 0);
    step(32'h0, 0, 1, 32'h200);
    step(32'h0, 0, 1, 32'h201);
    step(32'h0, 0, 1, 32'h202);
    step(32'h4, 0, 1, 32'h203);
    idle(3);
    chk("t2_writes", 32'(wr_cnt - w0), 32'd5);
    chk("t2_hdr", last_hdr, 32'h0100_0004);
    chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t2_status", status_o, 32'h0004_020C);

    // Stop with zero words still yields a header.
    w0 = wr_cnt;
    step(32'h1, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h4, 0, 0, 0);
    idle(3);
    chk("t2z_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t2z_hdr", last_hdr, 32'h0200_0000);
    chk("t2z_status", status_o, 32'h0000_030C);

    // Abort after two words: no header.
    w0 = wr_cnt; d0 = done_cnt;
    step(32'h1, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 0, 1, 32'h400);
    step(32'h0, 0, 1, 32'h401);
    step(32'h8, 0, 0, 0);
    idle(2);
    chk("t3_writes", 32'(wr_cnt - w0), 32'd2);
    chk("t3_done_pulses", 32'(done_cnt - d0), 32'd0);
    chk("t3_status", status_o, 32'h0002_0310);
    step(32'h1, 0, 0, 0);
    idle(2);
    chk("t3_rearm_status", status_o, 32'h0000_0301);

    // Trigger and abort in the same ARMED cycle, with a valid word present.
    w0 = wr_cnt;
    step(32'h8, 1, 1, 32'hBAD);
    idle(2);
    chk("t4_status", status_o, 32'h0000_0310);
    chk("t4_writes", 32'(wr_cnt - w0), 32'd0);

    // Held arm gives one arm; arm edges during capture are ignored.
    for (int i = 0; i < 20; i++) step(32'h1, 0, 0, 0);
    chk("t5_armed", status_o, 32'h0000_0301);
    step(32'h1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step((i % 2 == 1) ? 32'h1 : 32'h0, 0, 1, 32'h500 + 32'(i));
    idle(3);
    chk("t5_hdr", last_hdr, 32'h0300_0008);
    chk("t5_status", status_o, 32'h0008_040C);
    step(32'h1, 0, 0, 0);
    idle(2);
    chk("t5_rearm", status_o, 32'h0000_0401);
    step(32'h2, 0, 0, 0);
    step(32'h4, 0, 0, 0);
    idle(2);
    chk("t5_hdr0", last_hdr, 32'h0400_0000);
    step(32'h10, 0, 0, 0);
    idle(2);
    chk("t5_clear", status_o, 32'h0000_0508);

    // Asynchronous reset between edges while a data strobe is out.
    step(32'h1, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 0, 1, 32'h600);
    step(32'h0, 0, 1, 32'h601);
    step(32'h0, 0, 1, 32'h602);
    chk("t6_strobe_before", {31'd0, bram_en_o}, 32'd1);
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_en", {31'd0, bram_en_o}, 32'h0);
    chk("t6_async_we", {28'd0, bram_we_o}, 32'h0);
    chk("t6_async_addr", bram_addr_o, 32'h0);
    chk("t6_async_status", status_o, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_post_status", status_o, 32'h0);
    step(32'h1, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 1, 0, 0);
    step(32'h0, 0, 1, 32'h700);
    step(32'h4, 0, 0, 0);
    idle(3);
    chk("t6_hdr", last_hdr, 32'h0000_0001);
    chk("t6_status", status_o, 32'h0001_010C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
